// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: FSM states, statistic
// width, per-stage bundle widths and small helper functions.
package pipe_pkg;

  localparam int STAT_W = 16;

  // Default bundle widths for each pipeline boundary.
  localparam int ID_EX_CTRL_W  = 24;
  localparam int ID_EX_DATA_W  = 64;
  localparam int EX_MEM_CTRL_W = 16;
  localparam int EX_MEM_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Encoding 2'd3 is unreachable and is treated as empty.
  function automatic logic state_holds_word(input pipe_state_e s);
    logic r;
    case (s)
      ST_ONE:  r = 1'b1;
      ST_FULL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v == {STAT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; updates on the falling
// clock edge to match the stage buffers it observes.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register; clear has priority over increment.
  always_ff @(negedge clk) begin
    if (clr) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// flush. Optional stall/flush statistics are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W            = ID_EX_DATA_W,
  parameter int CTRL_W            = ID_EX_CTRL_W,
  parameter int CLR_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  pipe_state_e       state_d,     state_q;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
  logic [DATA_W-1:0] main_data_d, main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_d, skid_data_q;

  logic accept_s;
  logic drain_s;
  logic out_valid_s;

  // in_ready depends on state only, so no combinational path from out_ready.
  assign in_ready    = (state_q != ST_FULL) & ~Reset;
  assign out_valid_s = state_holds_word(state_q);
  assign accept_s    = in_valid & in_ready;
  assign drain_s     = out_valid_s & out_ready;

  assign out_valid = out_valid_s;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid_s ? main_ctrl_q : {CTRL_W{1'b0}};

  // Next-state and datapath selection; flush overrides the handshake.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
      if (CLR_DATA_ON_FLUSH != 0) begin
        main_data_d = {DATA_W{1'b0}};
        skid_data_d = {DATA_W{1'b0}};
      end else begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
      end
    end else begin
      case (state_q)
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept_s) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        // ST_EMPTY and the illegal encoding share this arm.
        default: begin
          if (accept_s) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      endcase
    end
  end

  // Stage registers; Reset clears everything regardless of state.
  always_ff @(negedge clk) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic stall_evt_s;
  assign stall_evt_s = out_valid_s & ~out_ready;

  pipe_sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk (clk),
    .clr (Reset),
    .inc (stall_evt_s),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk (clk),
    .clr (Reset),
    .inc (flush),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: two instances differing only in
// CLR_DATA_ON_FLUSH; statistics checks compile when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          Reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready,  c_in_ready;
  logic          out_valid, c_out_valid;
  logic [CW-1:0] out_ctrl,  c_out_ctrl;
  logic [DW-1:0] out_data,  c_out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_cnt, c_stall_cnt;
  logic [STAT_W-1:0] flush_cnt, c_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(0)) dut (
    .clk(clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(1)) dut_clr (
    .clk(clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // State changes on the falling edge; sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    tick(); tick();
    check("init_out_valid", out_valid, 1'b0);
    check("init_in_ready_in_reset", in_ready, 1'b0);

    // Fill to ST_FULL, then Reset for two cycles.
    Reset = 1'b0;
    offer(64'hA1, 24'h000001); tick();
    offer(64'hA2, 24'h000002); tick();
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_data", out_data, 64'hA1);
    Reset = 1'b1; in_valid = 1'b0; tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 24'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    check("rst2_out_data", out_data, 64'h0);
    Reset = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Streaming at full throughput.
    out_ready = 1'b1;
    offer(64'h11, 24'h000011); tick();
    check("stream_v1", out_valid, 1'b1);
    check("stream_d1", out_data, 64'h11);
    check("stream_c1", out_ctrl, 24'h000011);
    offer(64'h22, 24'h000022); tick();
    check("stream_d2", out_data, 64'h22);
    offer(64'h33, 24'h000033); tick();
    check("stream_d3", out_data, 64'h33);
    check("stream_c3", out_ctrl, 24'h000033);
    in_valid = 1'b0; tick();
    check("stream_empty_v", out_valid, 1'b0);
    check("stream_empty_c", out_ctrl, 24'h0);

    // Backpressure into the skid entry.
    out_ready = 1'b0;
    offer(64'hA, 24'h00000A); tick();
    offer(64'hB, 24'h00000B); tick();
    check("bp_hold_a", out_data, 64'hA);
    check("bp_in_ready", in_ready, 1'b0);
    offer(64'hC, 24'h00000C); tick();
    check("bp_still_a", out_data, 64'hA);
    check("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1; tick();
    check("bp_out_b", out_data, 64'hB);
    check("bp_ctrl_b", out_ctrl, 24'h00000B);
    check("bp_ready_again", in_ready, 1'b1);
    tick();
    check("bp_out_c", out_data, 64'hC);
    check("bp_valid_c", out_valid, 1'b1);
    in_valid = 1'b0; tick();
    check("bp_drained", out_valid, 1'b0);

    // Flush in ST_FULL discards the simultaneous input.
    out_ready = 1'b0;
    offer(64'h51, 24'h000051); tick();
    offer(64'h52, 24'h000052); tick();
    flush = 1'b1; offer(64'hD, 24'h00000D); tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl", out_ctrl, 24'h0);
    check("flush_in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    check("flush_no_d", out_valid, 1'b0);

    // Data retention vs clearing on flush.
    out_ready = 1'b0;
    offer(64'h5A, 24'h0005A5); tick();
    check("keep_pre", out_data, 64'h5A);
    check("clr_pre", c_out_data, 64'h5A);
    flush = 1'b1; in_valid = 1'b0; tick();
    check("keep_data", out_data, 64'h5A);
    check("clr_data", c_out_data, 64'h0);
    check("keep_ctrl", out_ctrl, 24'h0);
    check("clr_ctrl", c_out_ctrl, 24'h0);
    check("clr_valid", c_out_valid, 1'b0);
    flush = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
    check("stat_rst_stall", stall_cnt, 16'h0);
    check("stat_rst_flush", flush_cnt, 16'h0);
    out_ready = 1'b0;
    offer(64'h77, 24'h000077); tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("stat_stall5", stall_cnt, 16'd5);
    out_ready = 1'b1; flush = 1'b1; tick(); tick();
    flush = 1'b0;
    check("stat_flush2", flush_cnt, 16'd2);
    check("stat_stall_kept", stall_cnt, 16'd5);
    out_ready = 1'b0;
    offer(64'h78, 24'h000078); tick();
    in_valid = 1'b0;
    repeat (65540) tick();
    check("stat_stall_sat", stall_cnt, 16'hFFFF);
    Reset = 1'b1; tick();
    check("stat_clr_stall", stall_cnt, 16'h0);
    check("stat_clr_flush", flush_cnt, 16'h0);
    Reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
